// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data cache to L2 arbiter.
//   state_e   : arbiter FSM states (IDLE, I_RD, D_RD, D_WR)
//   grantee_e : identifies which cache was granted most recently
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned LINE_W_DEF = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        I_RD = 2'd1,
        D_RD = 2'd2,
        D_WR = 2'd3
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grantee_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates icache line reads and dcache line reads/writes onto a single
// L2 port with at most one transaction outstanding.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_read, i_addr                  icache read request / line address
//   i_rdata, i_resp                 icache returned line / completion pulse
//   d_read, d_write, d_addr, d_wdata dcache request / address / write line
//   d_rdata, d_resp                 dcache returned line / completion pulse
//   l2_read, l2_write, l2_addr, l2_wdata  memory-side command (latched)
//   l2_rdata, l2_resp               memory returned line / completion
//   i_grants, d_grants              saturating accepted-transaction counts
//   proto_err                       sticky protocol-error flag
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,
    output logic [CNT_W-1:0]  i_grants,
    output logic [CNT_W-1:0]  d_grants,
    output logic              proto_err
);

    state_e              state_q, state_d;
    grantee_e            last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    i_cnt_q, i_cnt_d;
    logic [CNT_W-1:0]    d_cnt_q, d_cnt_d;
    logic                err_q, err_d;
    // Holds off arbitration for the first edge after reset release so the
    // earliest grant lands on the second rising edge.
    logic                ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= GNT_I;
            addr_q  <= '0;
            wdata_q <= '0;
            i_cnt_q <= '0;
            d_cnt_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            i_cnt_q <= i_cnt_d;
            d_cnt_q <= d_cnt_d;
            err_q   <= err_d;
            ready_q <= 1'b1;
        end
    end

    always_comb begin
        logic d_pend;
        state_d = state_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        i_cnt_d = i_cnt_q;
        d_cnt_d = d_cnt_q;
        err_d   = err_q;
        d_pend  = d_read || d_write;

        case (state_q)
            IDLE: begin
                if (l2_resp) begin
                    err_d = 1'b1;
                end
                if (ready_q) begin
                    // icache wins only when dcache is idle or dcache was the
                    // last grantee; every other pending case goes to dcache.
                    if (i_read && (!d_pend || last_q == GNT_D)) begin
                        state_d = I_RD;
                        last_d  = GNT_I;
                        addr_d  = i_addr;
                        wdata_d = d_wdata;
                        if (i_cnt_q != '1) i_cnt_d = i_cnt_q + CNT_W'(1);
                    end else if (d_pend) begin
                        state_d = d_write ? D_WR : D_RD;
                        last_d  = GNT_D;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        if (d_read && d_write) err_d = 1'b1;
                        if (d_cnt_q != '1) d_cnt_d = d_cnt_q + CNT_W'(1);
                    end
                end
            end
            I_RD: begin
                if (!i_read) err_d = 1'b1;
                if (l2_resp) state_d = IDLE;
            end
            D_RD: begin
                if (!d_read) err_d = 1'b1;
                if (l2_resp) state_d = IDLE;
            end
            D_WR: begin
                if (!d_write) err_d = 1'b1;
                if (l2_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign l2_read   = (state_q == I_RD) || (state_q == D_RD);
    assign l2_write  = (state_q == D_WR);
    assign l2_addr   = addr_q;
    assign l2_wdata  = wdata_q;
    assign i_rdata   = l2_rdata;
    assign d_rdata   = l2_rdata;
    assign i_resp    = l2_resp && (state_q == I_RD);
    assign d_resp    = l2_resp && ((state_q == D_RD) || (state_q == D_WR));
    assign i_grants  = i_cnt_q;
    assign d_grants  = d_cnt_q;
    assign proto_err = err_q;

endmodule
